seg7_disp_arb: RTL and testbench

- Shares the single 8-digit seven-segment display driver among NREQ requesters, e.g. PC trace, register probe, memory probe and status.
- Uses round-robin arbitration with a guaranteed minimum dwell time per source.
- Sits between the debug sources and the display driver. Drives that driver's 64-bit data input and its mode select (0 = hex characters, 1 = raw segment patterns).
- A pin override locks one source onto the display for single-step debugging.

---
 rtl/seg7_disp_arb.sv | 180 ++++++++++++++++++
 tb/tb_seg7_disp_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_disp_arb.sv
// seg7_disp_arb: shares one 8-digit seven-segment display driver among NREQ
// debug sources using round-robin arbitration with a minimum dwell per grant.
// A pin override locks a chosen source onto the display.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   req[NREQ]          per-source level request
//   req_data[64*NREQ]  source i data at [64*i+63:64*i]
//   req_mode[NREQ]     source i mode (0 hex, 1 raw segments)
//   pin_en, pin_idx    force the display to source pin_idx (ignored if >= NREQ)
//   disp_data, disp_mode  registered data/mode to the display driver
//   grant[NREQ]        one-hot pulse when a source newly gains the display
//   owner              index of the current/last displayed source
//   busy               high while showing or pinned
module seg7_disp_arb #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DWELL_CYCLES = 50000000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [64*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]      req_mode,
  input  logic                 pin_en,
  input  logic [2:0]           pin_idx,
  output logic [63:0]          disp_data,
  output logic                 disp_mode,
  output logic [NREQ-1:0]      grant,
  output logic [2:0]           owner,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SHOW, PINNED} state_t;

  state_t           state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      disp_data_q, disp_data_d;
  logic             disp_mode_q, disp_mode_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [2:0]       owner_q, owner_d;
  logic             busy_q, busy_d;

  // Sources padded to the full 3-bit index space so any index is in range.
  logic [63:0] src_data [8];
  logic [7:0]  src_mode;
  logic [7:0]  src_req;
  logic        pin_valid;
  logic        rr_found;
  logic [2:0]  rr_win;
  logic [2:0]  cand;

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      src_data[i] = '0;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      src_data[i] = req_data[64*i +: 64];
    end
    src_mode  = 8'(req_mode);
    src_req   = 8'(req);
    pin_valid = pin_en && ({29'b0, pin_idx} < NREQ);
  end

  // Round-robin search from last_q+1 upward. In SHOW it is only consulted at
  // dwell expiry, where the current owner must not win against itself.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = last_q;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 3'(({29'b0, last_q} + k) % NREQ);
      if (!rr_found && src_req[cand] &&
          !((state_q == SHOW) && (cand == owner_q))) begin
        rr_found = 1'b1;
        rr_win   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    disp_data_d = disp_data_q;
    disp_mode_d = disp_mode_q;
    grant_d     = '0;
    owner_d     = owner_q;
    busy_d      = busy_q;

    if (pin_valid) begin
      // Pin override wins from any state; counter is left frozen.
      state_d     = PINNED;
      owner_d     = pin_idx;
      disp_data_d = src_data[pin_idx];
      disp_mode_d = src_mode[pin_idx];
      busy_d      = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (rr_found) begin
            state_d     = SHOW;
            owner_d     = rr_win;
            last_d      = rr_win;
            grant_d     = (NREQ)'(1) << rr_win;
            disp_data_d = src_data[rr_win];
            disp_mode_d = src_mode[rr_win];
            cnt_d       = CNT_W'(DWELL_CYCLES - 1);
            busy_d      = 1'b1;
          end
        end
        SHOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (src_req[owner_q]) begin
              disp_data_d = src_data[owner_q];
              disp_mode_d = src_mode[owner_q];
            end
          end else if (rr_found) begin
            owner_d     = rr_win;
            last_d      = rr_win;
            grant_d     = (NREQ)'(1) << rr_win;
            disp_data_d = src_data[rr_win];
            disp_mode_d = src_mode[rr_win];
            cnt_d       = CNT_W'(DWELL_CYCLES - 1);
          end else if (src_req[owner_q]) begin
            disp_data_d = src_data[owner_q];
            disp_mode_d = src_mode[owner_q];
            cnt_d       = CNT_W'(DWELL_CYCLES - 1);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
        PINNED: begin
          // Release: an invalid pin_idx counts as release, so fall back to
          // the index that was actually pinned.
          state_d = IDLE;
          busy_d  = 1'b0;
          last_d  = ({29'b0, pin_idx} < NREQ) ? pin_idx : owner_q;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      last_q      <= 3'(NREQ - 1);
      cnt_q       <= '0;
      disp_data_q <= '0;
      disp_mode_q <= 1'b0;
      grant_q     <= '0;
      owner_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      disp_data_q <= disp_data_d;
      disp_mode_q <= disp_mode_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
    end
  end

  assign disp_data = disp_data_q;
  assign disp_mode = disp_mode_q;
  assign grant     = grant_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seg7_disp_arb.sv
// Directed self-checking bench for seg7_disp_arb (NREQ=4, DWELL_CYCLES=8).
module tb_seg7_disp_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DWELL = 8;

  logic            clk;
  logic            rstn;
  logic [3:0]      req;
  logic [255:0]    req_data;
  logic [3:0]      req_mode;
  logic            pin_en;
  logic [2:0]      pin_idx;
  logic [63:0]     disp_data;
  logic            disp_mode;
  logic [3:0]      grant;
  logic [2:0]      owner;
  logic            busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  localparam logic [63:0] D0  = 64'h0000_0000_0000_00A0;
  localparam logic [63:0] D1  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2  = 64'h0000_0000_1234_5678;
  localparam logic [63:0] D3  = 64'h3333_0000_3333_0000;
  localparam logic [63:0] D2B = 64'h0000_0000_CAFE_BABE;
  localparam logic [63:0] D1J = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [63:0] P2  = 64'h7E30_6D79_3300_5B5F;
  localparam logic [63:0] P2B = 64'h0102_0304_0506_0708;

  seg7_disp_arb #(.NREQ(NREQ), .DWELL_CYCLES(DWELL), .CNT_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .req_data  (req_data),
    .req_mode  (req_mode),
    .pin_en    (pin_en),
    .pin_idx   (pin_idx),
    .disp_data (disp_data),
    .disp_mode (disp_mode),
    .grant     (grant),
    .owner     (owner),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn     = 1'b0;
    req      = 4'b1111;
    req_mode = 4'b0101;
    pin_en   = 1'b0;
    pin_idx  = 3'd0;
    req_data = '0;
    req_data[0*64 +: 64] = D0;
    req_data[1*64 +: 64] = D1;
    req_data[2*64 +: 64] = D2;
    req_data[3*64 +: 64] = D3;

    // Reset with all requests high, then rotation 0,1,2,3,0 every 8 cycles.
    tick();
    tick();
    check("rst_data",  disp_data, 64'd0);
    check("rst_mode",  64'(disp_mode), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    rstn = 1'b1;
    tick();
    check("rot_first_grant", 64'(grant), 64'h1);
    check("rot_first_data",  disp_data, D0);
    check("rot_first_mode",  64'(disp_mode), 64'd1);
    check("rot_first_busy",  64'(busy), 64'd1);
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c % 8 == 0) begin
        check("rot_grant", 64'(grant), 64'(4'b0001 << ((c / 8) % 4)));
        check("rot_owner", 64'(owner), 64'((c / 8) % 4));
      end else begin
        check("rot_nogrant", 64'(grant), 64'd0);
      end
    end

    // Single source: held past dwell, live data update.
    rstn = 1'b0;
    req  = 4'b0100;
    tick();
    check("midrst_data",  disp_data, 64'd0);
    check("midrst_grant", 64'(grant), 64'd0);
    check("midrst_busy",  64'(busy), 64'd0);
    rstn = 1'b1;
    tick();
    check("single_grant", 64'(grant), 64'h4);
    check("single_owner", 64'(owner), 64'd2);
    check("single_data",  disp_data, D2);
    for (int t = 1; t <= 12; t++) begin
      tick();
      check("single_nogrant", 64'(grant), 64'd0);
      check("single_owner_hold", 64'(owner), 64'd2);
      check("single_live", disp_data, (t >= 3) ? D2B : D2);
      if (t == 2) req_data[2*64 +: 64] = D2B;
    end

    // Early drop: source 1 frozen until its dwell ends, then source 3.
    rstn = 1'b0;
    req  = 4'b1010;
    req_data[1*64 +: 64] = D1;
    tick();
    rstn = 1'b1;
    tick();
    check("drop_grant1", 64'(grant), 64'h2);
    check("drop_data1",  disp_data, D1);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t < 8) begin
        check("drop_nogrant", 64'(grant), 64'd0);
        check("drop_frozen",  disp_data, D1);
        if (t == 3) begin
          req = 4'b1000;
          req_data[1*64 +: 64] = D1J;
        end
      end else begin
        check("drop_grant3", 64'(grant), 64'h8);
        check("drop_owner3", 64'(owner), 64'd3);
        check("drop_data3",  disp_data, D3);
      end
    end

    // Pin override during SHOW of source 0.
    rstn = 1'b0;
    req  = 4'b0001;
    req_data[2*64 +: 64] = P2;
    tick();
    rstn = 1'b1;
    tick();
    check("pin_pre_grant", 64'(grant), 64'h1);
    tick();
    tick();
    pin_en  = 1'b1;
    pin_idx = 3'd2;
    tick();
    check("pin_owner", 64'(owner), 64'd2);
    check("pin_grant", 64'(grant), 64'd0);
    check("pin_data",  disp_data, P2);
    check("pin_mode",  64'(disp_mode), 64'd1);
    check("pin_busy",  64'(busy), 64'd1);
    req_data[2*64 +: 64] = P2B;
    tick();
    check("pin_track", disp_data, P2B);
    check("pin_grant2", 64'(grant), 64'd0);
    pin_idx = 3'd5;
    req     = 4'b0000;
    tick();
    check("pin_bad_busy",  64'(busy), 64'd0);
    check("pin_bad_owner", 64'(owner), 64'd2);
    check("pin_bad_data",  disp_data, P2B);
    pin_idx = 3'd2;
    tick();
    check("repin_busy",  64'(busy), 64'd1);
    check("repin_owner", 64'(owner), 64'd2);
    pin_en = 1'b0;
    req    = 4'b1001;
    tick();
    check("unpin_busy",  64'(busy), 64'd0);
    check("unpin_grant", 64'(grant), 64'd0);
    tick();
    check("unpin_next_grant", 64'(grant), 64'h8);
    check("unpin_next_owner", 64'(owner), 64'd3);
    check("unpin_next_data",  disp_data, D3);
    check("unpin_next_mode",  64'(disp_mode), 64'd0);

    // Idle hold: requests drop, dwell completes, display retained.
    req = 4'b0000;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check("idle_nogrant", 64'(grant), 64'd0);
      check("idle_busy",    64'(busy), (t < 8) ? 64'd1 : 64'd0);
      check("idle_data",    disp_data, D3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
